// File: rtl/fft_twiddle_gen.sv
// Twiddle-factor producer for the radix-2 butterfly: streams W = w_r + j*w_i for one
// stage over valid/ready, folded from a quarter-wave cosine table.
module fft_twiddle_gen #(
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       stage,
  input  logic             inv,
  output logic             busy,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic [9:0]       w_r,
  output logic [9:0]       w_i,
  output logic [LOG2N-2:0] tw_idx,
  output logic             tw_last
);

  localparam int JW   = LOG2N - 1;
  localparam int E_SH = 6 - LOG2N;
  localparam logic [JW-1:0] J_LAST = '1;

  generate
    if (LOG2N < 4 || LOG2N > 6) begin : g_bad_log2n
      $error("fft_twiddle_gen: LOG2N must be in 4..6");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      stage_q, stage_d;
  logic            inv_q, inv_d;
  logic [JW-1:0]   idx_q, idx_d;
  logic [9:0]      wr_q, wr_d, wi_q, wi_d;
  logic            last_q, last_d;
  logic            load, adv, fin;

  // round(256*cos(2*pi*m/64)), m = 0..16
  function automatic logic [9:0] qrom(input logic [4:0] m);
    case (m)
      5'd0:  qrom = 10'd256;
      5'd1:  qrom = 10'd255;
      5'd2:  qrom = 10'd251;
      5'd3:  qrom = 10'd245;
      5'd4:  qrom = 10'd237;
      5'd5:  qrom = 10'd226;
      5'd6:  qrom = 10'd213;
      5'd7:  qrom = 10'd198;
      5'd8:  qrom = 10'd181;
      5'd9:  qrom = 10'd162;
      5'd10: qrom = 10'd142;
      5'd11: qrom = 10'd121;
      5'd12: qrom = 10'd98;
      5'd13: qrom = 10'd74;
      5'd14: qrom = 10'd50;
      5'd15: qrom = 10'd25;
      default: qrom = 10'd0;
    endcase
  endfunction

  // Twiddle for the index about to be loaded (j=0 on start, idx+1 on advance)
  logic [JW-1:0] tj;
  logic [2:0]    ts, sh;
  logic          ti, e_hi;
  logic [4:0]    j5, mask5, k5, e5, qa, qb;
  logic [9:0]    tw_r, tw_i;

  always_comb begin
    tj    = load ? '0 : idx_q + JW'(1);
    ts    = load ? stage : stage_q;
    ti    = load ? inv : inv_q;
    j5    = 5'(tj);
    sh    = 3'(JW) - ts;
    mask5 = ~(5'h1f << sh);
    k5    = (j5 & mask5) << ts;
    e5    = k5 << E_SH;
    e_hi  = e5 > 5'd16;
    // Second quadrant folds onto 32-e for cosine; sine index is |e-16|
    qa    = e_hi ? 5'd0 - e5 : e5;
    qb    = e_hi ? e5 - 5'd16 : 5'd16 - e5;
    tw_r  = e_hi ? -qrom(qa) : qrom(qa);
    tw_i  = ti ? qrom(qb) : -qrom(qb);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && stage < 3'(LOG2N)) state_d = RUN;
      RUN:  if (tw_ready && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == IDLE) && start && (stage < 3'(LOG2N));
    adv  = (state_q == RUN) && tw_ready && !last_q;
    fin  = (state_q == RUN) && tw_ready && last_q;
  end

  always_comb begin
    stage_d = stage_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wi_d    = wi_q;
    last_d  = last_q;
    if (load) begin
      stage_d = stage;
      inv_d   = inv;
    end
    if (load || adv) begin
      idx_d  = tj;
      wr_d   = tw_r;
      wi_d   = tw_i;
      last_d = (tj == J_LAST);
    end else if (fin) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
      wr_q    <= '0;
      wi_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wi_q    <= wi_d;
      last_q  <= last_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign tw_valid = (state_q == RUN);
  assign w_r      = wr_q;
  assign w_i      = wi_q;
  assign tw_idx   = idx_q;
  assign tw_last  = last_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed bench for fft_twiddle_gen (LOG2N=6): hand-computed twiddle table,
// stalls, ignored starts and mid-run reset.
module tb_fft_twiddle_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] stage;
  logic       inv;
  logic       busy;
  logic       tw_valid;
  logic       tw_ready;
  logic [9:0] w_r, w_i;
  logic [4:0] tw_idx;
  logic       tw_last;

  int n_total = 0;
  int n_bad   = 0;

  int rec_r[32];
  int rec_i[32];
  int rec_idx[32];

  // Stage 0, forward: W^j for N=64, hand-derived from the quarter-wave table
  int exp_r[32] = '{256, 255, 251, 245, 237, 226, 213, 198, 181, 162, 142, 121, 98, 74, 50, 25,
                    0, -25, -50, -74, -98, -121, -142, -162, -181, -198, -213, -226, -237, -245, -251, -255};
  int exp_i[32] = '{0, -25, -50, -74, -98, -121, -142, -162, -181, -198, -213, -226, -237, -245, -251, -255,
                    -256, -255, -251, -245, -237, -226, -213, -198, -181, -162, -142, -121, -98, -74, -50, -25};

  fft_twiddle_gen #(.LOG2N(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stage    (stage),
    .inv      (inv),
    .busy     (busy),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .w_r      (w_r),
    .w_i      (w_i),
    .tw_idx   (tw_idx),
    .tw_last  (tw_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sr(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  // One stage run; records every accepted twiddle. Called and returns on a negedge.
  task automatic run_stage(input logic [2:0] s, input logic v, input bit rand_rdy, input bit poke);
    int  n, cyc;
    bit  stalled;
    int  pr, pi, pidx, plast;
    start = 1'b1; stage = s; inv = v; tw_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_valid", tw_valid, 1);
    chk("start_busy", busy, 1);
    n = 0; cyc = 0; stalled = 1'b0;
    pr = 0; pi = 0; pidx = 0; plast = 0;
    while (n < 32 && cyc < 400) begin
      chk("run_valid", tw_valid, 1);
      if (stalled) begin
        chk("hold_wr", sr(w_r), pr);
        chk("hold_wi", sr(w_i), pi);
        chk("hold_idx", tw_idx, pidx);
        chk("hold_last", tw_last, plast);
      end
      tw_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        stage = 3'($urandom_range(0, 7));
      end
      if (tw_valid && tw_ready) begin
        rec_r[n]   = sr(w_r);
        rec_i[n]   = sr(w_i);
        rec_idx[n] = int'(tw_idx);
        chk("last_flag", tw_last, (n == 31) ? 1 : 0);
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pr = sr(w_r); pi = sr(w_i); pidx = int'(tw_idx); plast = int'(tw_last);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; stage = s;
    chk("handshakes", n, 32);
    chk("end_valid", tw_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", tw_last, 0);
    chk("end_idx_hold", tw_idx, 31);
    chk("end_wr_hold", sr(w_r), rec_r[31]);
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", tw_valid, 0);
    end
    $display("run stage=%0d inv=%0d stall=%0d poke=%0d: %0d twiddles in %0d cycles",
             s, v, rand_rdy, poke, n, cyc);
  endtask

  task automatic chk_stage0(input bit v);
    for (int j = 0; j < 32; j++) begin
      chk("s0_idx", rec_idx[j], j);
      chk("s0_wr", rec_r[j], exp_r[j]);
      chk("s0_wi", rec_i[j], v ? -exp_i[j] : exp_i[j]);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; stage = 3'd0; inv = 1'b0; tw_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", tw_valid, 0);
    chk("rst_last", tw_last, 0);
    chk("rst_wr", sr(w_r), 0);
    chk("rst_wi", sr(w_i), 0);
    chk("rst_idx", tw_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    run_stage(3'd0, 1'b0, 1'b0, 1'b0);
    chk_stage0(1'b0);
    chk("s0_j31_wr", rec_r[31], -255);
    chk("s0_j31_wi", rec_i[31], -25);

    run_stage(3'd1, 1'b0, 1'b0, 1'b0);
    chk("s1_j1_wr", rec_r[1], 251);
    chk("s1_j1_wi", rec_i[1], -50);
    chk("s1_j8_wr", rec_r[8], 0);
    chk("s1_j8_wi", rec_i[8], -256);
    chk("s1_j16_wr", rec_r[16], 256);
    chk("s1_j16_wi", rec_i[16], 0);
    chk("s1_j31_wr", rec_r[31], -251);
    chk("s1_j31_wi", rec_i[31], -50);

    run_stage(3'd5, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 32; j++) begin
      chk("s5_wr", rec_r[j], 256);
      chk("s5_wi", rec_i[j], 0);
    end

    run_stage(3'd0, 1'b1, 1'b0, 1'b0);
    chk_stage0(1'b1);
    chk("inv_j8_wi", rec_i[8], 181);
    chk("inv_j16_wi", rec_i[16], 256);

    run_stage(3'd0, 1'b0, 1'b1, 1'b0);
    chk_stage0(1'b0);

    run_stage(3'd0, 1'b0, 1'b0, 1'b1);
    chk_stage0(1'b0);

    // Out-of-range stage in IDLE must not start a run
    start = 1'b1; stage = 3'd6;
    @(negedge clk);
    start = 1'b0;
    chk("bad_stage_busy", busy, 0);
    chk("bad_stage_valid", tw_valid, 0);
    start = 1'b1; stage = 3'd7;
    @(negedge clk);
    start = 1'b0; stage = 3'd0;
    chk("bad7_busy", busy, 0);
    @(negedge clk);
    chk("bad7_valid", tw_valid, 0);

    // Reset in the middle of a run
    start = 1'b1; stage = 3'd0; inv = 1'b0; tw_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (tw_idx != 5'd10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_j10", tw_idx, 10);
    chk("j10_wr", sr(w_r), 142);
    chk("j10_wi", sr(w_i), -213);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", tw_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", sr(w_r), 0);
    chk("mid_rst_wi", sr(w_i), 0);
    chk("mid_rst_idx", tw_idx, 0);
    chk("mid_rst_last", tw_last, 0);
    @(negedge clk);
    chk("post_rst_idle", tw_valid, 0);
    run_stage(3'd0, 1'b0, 1'b0, 1'b0);
    chk("restart_j0_wr", rec_r[0], 256);
    chk("restart_j0_wi", rec_i[0], 0);
    chk_stage0(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
